// File: rtl/nubus_master.sv
// NuBus bus-master sequencer: arbitration, address, data and NULL-ATTN cycles.
// Optional DATA-phase timeout is built when NUBUS_MASTER_TIMEOUT_EN is defined.
module nubus_master (
  input  logic       nub_clkn,
  input  logic       nub_resetn,
  input  logic       cpu_reqn,
  input  logic       cpu_lockedn,
  input  logic       cpu_tm1n,
  input  logic       cpu_tm0n,
  input  logic       arb_grantn,
  input  logic       nub_startn,
  input  logic       nub_ackn,
  input  logic       nub_tm1n,
  input  logic       nub_tm0n,
  output logic       mst_arbcyn,
  output logic       mst_adrcyn,
  output logic       mst_dtacyn,
  output logic       mst_ownern,
  output logic       mst_lockedn,
  output logic       mst_tm1n,
  output logic       mst_tm0n,
  output logic       cpu_donen,
  output logic       cpu_timeoutn,
  output logic [1:0] cpu_status,
  output logic       cpu_busyn
);

  typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, ATTN} state_t;

  state_t     state, state_nx;
  logic       locked;
  logic       bus_busy;
  logic [1:0] arb_cnt;
  logic       latch_req, latch_cont, clr_locked, ack_hit, to_hit;
  logic       to_expire;

`ifdef NUBUS_MASTER_TIMEOUT_EN
  logic [7:0] to_cnt;

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn)                    to_cnt <= '0;
    else if (state == ADDR)             to_cnt <= '0;
    else if (state == DATA && nub_ackn) to_cnt <= to_cnt + 8'd1;
  end

  assign to_expire = (to_cnt == 8'hff);
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    latch_req  = 1'b0;
    latch_cont = 1'b0;
    clr_locked = 1'b0;
    ack_hit    = 1'b0;
    to_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (!cpu_reqn) begin
          state_nx  = ARB;
          latch_req = 1'b1;
        end
      end
      ARB: begin
        if (arb_cnt >= 2'd2 && !bus_busy && !arb_grantn) state_nx = ADDR;
      end
      ADDR: state_nx = DATA;
      DATA: begin
        // ACK is checked first so it wins over a same-clock timeout
        if (!nub_ackn) begin
          ack_hit = 1'b1;
          if (locked && !cpu_reqn && !cpu_lockedn) begin
            state_nx   = ADDR;
            latch_cont = 1'b1;
          end else if (locked) begin
            state_nx   = ATTN;
            clr_locked = 1'b1;
          end else begin
            state_nx   = IDLE;
          end
        end else if (to_expire) begin
          state_nx   = IDLE;
          to_hit     = 1'b1;
          clr_locked = 1'b1;
        end
      end
      ATTN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      locked       <= 1'b0;
      bus_busy     <= 1'b0;
      arb_cnt      <= '0;
      mst_tm1n     <= 1'b1;
      mst_tm0n     <= 1'b1;
      cpu_status   <= 2'b11;
      cpu_donen    <= 1'b1;
      cpu_timeoutn <= 1'b1;
    end else begin
      cpu_donen    <= ~ack_hit;
      cpu_timeoutn <= ~to_hit;
      if (latch_req || latch_cont) begin
        mst_tm1n <= cpu_tm1n;
        mst_tm0n <= cpu_tm0n;
      end
      if (latch_req)       locked <= ~cpu_lockedn;
      else if (clr_locked) locked <= 1'b0;
      if (ack_hit) cpu_status <= {nub_tm1n, nub_tm0n};
      // Bus tenure is tracked in every state so a transfer already under way
      // when we enter ARB still holds us off.
      if (!nub_startn)    bus_busy <= 1'b1;
      else if (!nub_ackn) bus_busy <= 1'b0;
      if (state != ARB || !nub_startn) arb_cnt <= '0;
      else if (arb_cnt != 2'd3)        arb_cnt <= arb_cnt + 2'd1;
    end
  end

  assign mst_arbcyn  = ~(state == ARB || state == ADDR || state == ATTN ||
                         (state == DATA && locked));
  assign mst_adrcyn  = ~(state == ADDR);
  assign mst_dtacyn  = ~(state == DATA);
  assign mst_ownern  = ~(state == ADDR || state == DATA || state == ATTN);
  assign mst_lockedn = ~locked;
  assign cpu_busyn   = (state == IDLE);

endmodule

// File: tb/tb_nubus_master.sv
// Directed bench for nubus_master: completions go through a scoreboard queue,
// bus-cycle decodes are checked cycle by cycle from the stimulus thread.
module tb_nubus_master;

  logic       nub_clkn = 1'b0;
  logic       nub_resetn;
  logic       cpu_reqn, cpu_lockedn, cpu_tm1n, cpu_tm0n, arb_grantn;
  logic       nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
  logic       mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn;
  logic       mst_tm1n, mst_tm0n, cpu_donen, cpu_timeoutn, cpu_busyn;
  logic [1:0] cpu_status;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       is_to;
    logic [1:0] st;
  } exp_t;
  exp_t sb[$];

  // {arbcyn, adrcyn, dtacyn, ownern, lockedn, busyn}
  localparam logic [5:0] D_IDLE  = 6'b111111;
  localparam logic [5:0] D_ARB   = 6'b011110;
  localparam logic [5:0] D_ADDR  = 6'b001010;
  localparam logic [5:0] D_DATA  = 6'b110010;
  localparam logic [5:0] D_ARBL  = 6'b011100;
  localparam logic [5:0] D_ADDRL = 6'b001000;
  localparam logic [5:0] D_DATAL = 6'b010000;
  localparam logic [5:0] D_ATTN  = 6'b011010;

  always #5 nub_clkn = ~nub_clkn;

  nubus_master dut (
    .nub_clkn    (nub_clkn),
    .nub_resetn  (nub_resetn),
    .cpu_reqn    (cpu_reqn),
    .cpu_lockedn (cpu_lockedn),
    .cpu_tm1n    (cpu_tm1n),
    .cpu_tm0n    (cpu_tm0n),
    .arb_grantn  (arb_grantn),
    .nub_startn  (nub_startn),
    .nub_ackn    (nub_ackn),
    .nub_tm1n    (nub_tm1n),
    .nub_tm0n    (nub_tm0n),
    .mst_arbcyn  (mst_arbcyn),
    .mst_adrcyn  (mst_adrcyn),
    .mst_dtacyn  (mst_dtacyn),
    .mst_ownern  (mst_ownern),
    .mst_lockedn (mst_lockedn),
    .mst_tm1n    (mst_tm1n),
    .mst_tm0n    (mst_tm0n),
    .cpu_donen   (cpu_donen),
    .cpu_timeoutn(cpu_timeoutn),
    .cpu_status  (cpu_status),
    .cpu_busyn   (cpu_busyn)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] dec_v();
    return {mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn, cpu_busyn};
  endfunction

  task automatic cyc();
    @(negedge nub_clkn);
  endtask

  task automatic expect_resp(input logic is_to, input logic [1:0] st);
    exp_t e;
    e.is_to = is_to;
    e.st    = st;
    sb.push_back(e);
  endtask

  // Completion monitor: every done/timeout pulse cycle consumes one entry
  always @(negedge nub_clkn) begin
    if (nub_resetn && (!cpu_donen || !cpu_timeoutn)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse donen=%b timeoutn=%b required=none", cpu_donen, cpu_timeoutn);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_onehot", {31'b0, cpu_donen ^ cpu_timeoutn}, 32'd1);
        chk("resp_kind", {31'b0, ~cpu_timeoutn}, {31'b0, e.is_to});
        chk("resp_status", {30'b0, cpu_status}, {30'b0, e.st});
      end
    end
  end

  initial begin
    nub_resetn  = 1'b0;
    cpu_reqn    = 1'b1;
    cpu_lockedn = 1'b1;
    cpu_tm1n    = 1'b1;
    cpu_tm0n    = 1'b1;
    arb_grantn  = 1'b0;
    nub_startn  = 1'b1;
    nub_ackn    = 1'b1;
    nub_tm1n    = 1'b1;
    nub_tm0n    = 1'b1;

    repeat (2) cyc();
    chk("rst_dec", dec_v(), D_IDLE);
    chk("rst_tm", {mst_tm1n, mst_tm0n}, 2'b11);
    chk("rst_status", cpu_status, 2'b11);
    chk("rst_pulses", {cpu_donen, cpu_timeoutn}, 2'b11);
    nub_resetn = 1'b1;

    // normal write, quiet bus, grant held low
    cyc();
    chk("idle_hold", dec_v(), D_IDLE);
    cpu_reqn = 1'b0; cpu_tm1n = 1'b0; cpu_tm0n = 1'b1;
    cyc();
    cpu_reqn = 1'b1; cpu_tm1n = 1'b1; cpu_tm0n = 1'b1;
    chk("wr_arb1", dec_v(), D_ARB);
    cyc(); chk("wr_arb2", dec_v(), D_ARB);
    cyc(); chk("wr_arb3", dec_v(), D_ARB);
    cyc(); chk("wr_addr", dec_v(), D_ADDR);
    chk("wr_tm", {mst_tm1n, mst_tm0n}, 2'b01);
    cyc(); chk("wr_data", dec_v(), D_DATA);
    nub_ackn = 1'b0; nub_tm1n = 1'b0; nub_tm0n = 1'b0;
    expect_resp(1'b0, 2'b00);
    cyc();
    nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
    chk("wr_idle", dec_v(), D_IDLE);
    chk("wr_status", cpu_status, 2'b00);

    // reset in the middle of DATA
    cpu_reqn = 1'b0; cpu_tm1n = 1'b1; cpu_tm0n = 1'b0;
    cyc();
    cpu_reqn = 1'b1;
    repeat (4) cyc();
    chk("rd_data", dec_v(), D_DATA);
    chk("rd_tm", {mst_tm1n, mst_tm0n}, 2'b10);
    #2 nub_resetn = 1'b0;
    #1;
    chk("mid_rst_dec", dec_v(), D_IDLE);
    chk("mid_rst_tm", {mst_tm1n, mst_tm0n}, 2'b11);
    chk("mid_rst_status", cpu_status, 2'b11);
    chk("mid_rst_pulses", {cpu_donen, cpu_timeoutn}, 2'b11);
    cpu_reqn = 1'b0; cpu_tm1n = 1'b1; cpu_tm0n = 1'b1;
    cyc();
    nub_resetn = 1'b1;
    cyc();
    cpu_reqn = 1'b1;
    chk("first_edge_req", dec_v(), D_ARB);

    // foreign start during ARB restarts the count
    cyc(); nub_startn = 1'b0;
    cyc(); nub_startn = 1'b1; nub_ackn = 1'b0;
    chk("fs_arb_a", dec_v(), D_ARB);
    cyc(); nub_ackn = 1'b1;
    chk("fs_arb_b", dec_v(), D_ARB);
    cyc(); chk("fs_arb_c", dec_v(), D_ARB);
    cyc(); chk("fs_addr", dec_v(), D_ADDR);
    chk("fs_tm", {mst_tm1n, mst_tm0n}, 2'b11);
    cyc(); chk("fs_data", dec_v(), D_DATA);
    nub_ackn = 1'b0; nub_tm1n = 1'b1; nub_tm0n = 1'b0;
    expect_resp(1'b0, 2'b10);
    cyc();
    nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
    chk("fs_idle", dec_v(), D_IDLE);
    chk("fs_status", cpu_status, 2'b10);

    // locked pair, grant withheld for a while first
    cpu_reqn = 1'b0; cpu_lockedn = 1'b0; cpu_tm1n = 1'b0; cpu_tm0n = 1'b0;
    arb_grantn = 1'b1;
    cyc(); chk("lk_arb0", dec_v(), D_ARBL);
    cpu_tm1n = 1'b1; cpu_tm0n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc(); chk("lk_arb_nogrant", dec_v(), D_ARBL);
    end
    arb_grantn = 1'b0;
    cyc(); chk("lk_addr1", dec_v(), D_ADDRL);
    chk("lk_tm1", {mst_tm1n, mst_tm0n}, 2'b00);
    cyc(); chk("lk_data1", dec_v(), D_DATAL);
    nub_ackn = 1'b0; nub_tm1n = 1'b0; nub_tm0n = 1'b1;
    expect_resp(1'b0, 2'b01);
    cyc(); chk("lk_addr2", dec_v(), D_ADDRL);
    chk("lk_tm2", {mst_tm1n, mst_tm0n}, 2'b11);
    nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
    cpu_reqn = 1'b1; cpu_lockedn = 1'b1;
    cyc(); chk("lk_data2", dec_v(), D_DATAL);
    nub_ackn = 1'b0;
    expect_resp(1'b0, 2'b11);
    cyc(); chk("lk_attn", dec_v(), D_ATTN);
    nub_ackn = 1'b1;
    cyc(); chk("lk_idle", dec_v(), D_IDLE);

`ifdef NUBUS_MASTER_TIMEOUT_EN
    // no ACK: timeout after 256 DATA clocks, status untouched
    cpu_reqn = 1'b0;
    cyc(); cpu_reqn = 1'b1;
    repeat (3) cyc();
    chk("to_addr", dec_v(), D_ADDR);
    repeat (256) cyc();
    chk("to_data_last", dec_v(), D_DATA);
    expect_resp(1'b1, 2'b11);
    cyc(); chk("to_idle", dec_v(), D_IDLE);
    chk("to_status", cpu_status, 2'b11);
    // ACK on the 256th DATA clock beats the timeout
    cpu_reqn = 1'b0;
    cyc(); cpu_reqn = 1'b1;
    repeat (3) cyc();
    repeat (256) cyc();
    chk("tie_data", dec_v(), D_DATA);
    nub_ackn = 1'b0; nub_tm1n = 1'b0; nub_tm0n = 1'b0;
    expect_resp(1'b0, 2'b00);
    cyc();
    nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
    chk("tie_idle", dec_v(), D_IDLE);
`else
    // without the timeout, DATA waits for ACK indefinitely
    cpu_reqn = 1'b0;
    cyc(); cpu_reqn = 1'b1;
    repeat (3) cyc();
    chk("wait_addr", dec_v(), D_ADDR);
    repeat (300) cyc();
    chk("wait_data", dec_v(), D_DATA);
    chk("wait_no_to", {31'b0, cpu_timeoutn}, 32'd1);
    nub_ackn = 1'b0; nub_tm1n = 1'b0; nub_tm0n = 1'b0;
    expect_resp(1'b0, 2'b00);
    cyc();
    nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
    chk("wait_idle", dec_v(), D_IDLE);
`endif
    chk("end_status", cpu_status, 2'b00);

    repeat (3) cyc();
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
